mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller arbitrating instruction fetch (IF) and data access (MEM) onto one byte-wide, single-port synchronous RAM. It serialises 32-bit accesses into byte transactions and sources the `stallreq_from_if` / `stallreq_from_mem` requests consumed by the pipeline stall controller. MEM has priority over IF because MEM belongs to the older instruction.

## Interface

- No parameters. Size encodings come from `mem_ctrl_pkg`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_done`.
- `if_addr`  in  32  fetch byte address.
- `if_data`  out  32  fetched word; registered.
- `if_done`  out  1  one-cycle completion pulse.
- `stallreq_from_if`  out  1  fetch pending, not completing this cycle.
- `mem_req`  in  1  data request; held until `mem_done`.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_size`  in  2  0 byte, 1 half, 2 word (3 treated as word).
- `mem_addr`  in  32  data byte address.
- `mem_wdata`  in  32  store data; low bytes used for byte and half.
- `mem_rdata`  out  32  load data, zero-extended; registered.
- `mem_done`  out  1  one-cycle completion pulse.
- `stallreq_from_mem`  out  1  data access pending, not completing this cycle.
- `ram_addr`  out  32  RAM byte address.
- `ram_dout`  out  8  RAM write byte.
- `ram_wr`  out  1  RAM write enable.
- `ram_din`  in  8  RAM read byte; valid one cycle after its address.

## Operation

- States:
  - IDLE: samples requests.
  - RD: read bytes; counter `cnt` runs 0..n.
  - WR: write bytes; `cnt` runs 0..n-1.
  - DONE: one cycle; pulses done.
- Byte count n = 1, 2 or 4 from `mem_size`. IF is always n = 4.
- IDLE:
  - `mem_req` wins if both requests are high.
  - Latch owner, base address, n, and write data. Go to WR if store, else RD. Set `cnt` = 0.
- RD:
  - `ram_addr` = base + `cnt`, for `cnt` < n. At `cnt` = n, hold the last address.
  - Each cycle with `cnt` ≥ 1, capture `ram_din` into byte `cnt`-1 of the assembly register. Byte order is little-endian.
  - After `cnt` = n, go to DONE.
- WR:
  - `ram_addr` = base + `cnt`, `ram_wr` = 1, `ram_dout` = write byte `cnt`.
  - After `cnt` = n-1, go to DONE.
- DONE:
  - Assert the owner's done pulse.
  - For reads, the owner's data output takes the assembled value, with unused upper bytes zeroed. The other port's data output is unchanged.
  - Return to IDLE.
- Data outputs hold their value until the next completion on their own port.
- `stallreq_from_x` = `x_req` AND NOT (state == DONE AND owner == x). The losing port keeps stalling through the whole winner transaction.
- Address arithmetic is 32-bit modular; 0xFFFFFFFF + 1 wraps to 0. No alignment check.
- A request dropped mid-transaction does not abort it; done still pulses.
- `ram_wr` is 0 in every state except WR. `ram_addr` and `ram_dout` are 0 in IDLE.

## Timing

- Request accepted in IDLE cycle T.
- Reads (n bytes):
  - RD occupies T+1..T+n+1.
  - done at T+n+2: word read T+6, half T+4, byte T+3.
- Writes (n bytes):
  - WR occupies T+1..T+n.
  - done at T+n+1: word write T+5, byte T+2.
- IDLE always separates transactions. A request held after done is re-sampled at T+done+1 (e.g. back-to-back fetches are 7 cycles apart).
- Reset values: state IDLE, `cnt` 0, `if_data` 0, `mem_rdata` 0, both done pulses 0, `ram_wr` 0, `ram_addr` 0, `ram_dout` 0.
- Stall outputs are combinational: they equal the request inputs while in IDLE after reset.
- Reset mid-transaction: next edge returns to IDLE, `ram_wr` drops, no done pulse, the partial word is discarded.

## Structure

- `mem_ctrl_pkg` holds:
  - size encodings `SIZE_B`, `SIZE_H`, `SIZE_W`;
  - state enum IDLE/RD/WR/DONE;
  - owner encoding `OWN_IF` / `OWN_MEM`.
- Single module; no sub-module is warranted. Byte assembly and lane select are inline logic.

## Test plan

- Word fetch: RAM[0x1000..0x1003] = 93 00 A0 00, `if_req` at T.
  - `if_data` = 0x00A00093 and `if_done` = 1 at T+6.
  - `stallreq_from_if` = 1 over T..T+5 and 0 at T+6.
- Simultaneous requests: `if_req` and `mem_req` (load word, 0x2000 = 0xDEADBEEF) both high at T.
  - `mem_done` at T+6 with `mem_rdata` = 0xDEADBEEF.
  - IF accepted at T+7; `if_done` at T+13.
- Byte store: `mem_wdata` = 0x12345678, size byte, addr 0x3003.
  - One cycle with `ram_wr` = 1, `ram_addr` = 0x3003, `ram_dout` = 0x78.
  - `mem_done` at T+2.
- Half load at 0xFFFFFFFF, with RAM[0xFFFFFFFF] = 0xCD and RAM[0] = 0xAB.
  - Addresses presented are 0xFFFFFFFF then 0x00000000.
  - `mem_rdata` = 0x0000ABCD at T+4.
- Reset during a word store at T+2:
  - `ram_wr` = 0 from T+3; no `mem_done`.
  - All outputs at reset values; a fresh request then completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serialising memory controller.
package mem_ctrl_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // Byte count for a data access; the reserved encoding behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = 3'd1;
      SIZE_H:  size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM 32-bit accesses onto a byte-wide synchronous RAM,
// serialising each access into 1, 2 or 4 byte transactions. MEM wins ties.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  output logic        stallreq_from_if,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        stallreq_from_mem,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  state_t      state;
  owner_t      owner;
  logic [2:0]  cnt;
  logic [2:0]  n;
  logic [31:0] wbuf;
  logic [31:0] asm_q;
  logic [1:0]  lane;
  logic [31:0] rd_word;

  // ram_din returns the byte addressed one cycle earlier, i.e. lane cnt-1.
  assign lane = cnt[1:0] - 2'd1;

  always_comb begin
    rd_word = asm_q;
    rd_word[{lane, 3'b000} +: 8] = ram_din;
  end

  assign stallreq_from_if  = if_req  & ~(state == DONE && owner == OWN_IF);
  assign stallreq_from_mem = mem_req & ~(state == DONE && owner == OWN_MEM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      cnt       <= '0;
      n         <= '0;
      wbuf      <= '0;
      asm_q     <= '0;
      if_data   <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_dout  <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt   <= '0;
          asm_q <= '0;
          if (mem_req) begin
            owner    <= OWN_MEM;
            n        <= size_bytes(mem_size);
            ram_addr <= mem_addr;
            if (mem_we) begin
              state    <= WR;
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
              wbuf     <= {8'h00, mem_wdata[31:8]};
            end else begin
              state <= RD;
            end
          end else if (if_req) begin
            owner    <= OWN_IF;
            n        <= 3'd4;
            ram_addr <= if_addr;
            state    <= RD;
          end
        end
        RD: begin
          cnt <= cnt + 3'd1;
          if (cnt != 3'd0) asm_q[{lane, 3'b000} +: 8] <= ram_din;
          // The final cycle only collects the last byte; the address holds.
          if (cnt + 3'd1 < n) ram_addr <= ram_addr + 32'd1;
          if (cnt == n) begin
            state    <= DONE;
            cnt      <= '0;
            ram_addr <= '0;
            if (owner == OWN_IF) begin
              if_data <= rd_word;
              if_done <= 1'b1;
            end else begin
              mem_rdata <= rd_word;
              mem_done  <= 1'b1;
            end
          end
        end
        WR: begin
          if (cnt == n - 3'd1) begin
            state    <= DONE;
            cnt      <= '0;
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_dout <= '0;
            mem_done <= 1'b1;
          end else begin
            cnt      <= cnt + 3'd1;
            ram_addr <= ram_addr + 32'd1;
            ram_dout <= wbuf[7:0];
            wbuf     <= wbuf >> 8;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 64 KiB byte RAM model (low 16 address bits).
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        stallreq_from_if;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stallreq_from_mem;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram [0:65535];
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (ram_wr) ram[ram_addr[15:0]] <= ram_dout;
    ram_din <= ram[ram_addr[15:0]];
  end

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .stallreq_from_if(stallreq_from_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stallreq_from_mem(stallreq_from_mem),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    if_req = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    checks++; if (stallreq_from_if !== 1'b1) begin errors++; $display("FAIL rst_stall_if got %b exp 1", stallreq_from_if); end
    checks++; if (stallreq_from_mem !== 1'b0) begin errors++; $display("FAIL rst_stall_mem got %b exp 0", stallreq_from_mem); end
    checks++; if ({if_data, mem_rdata} !== 64'h0) begin errors++; $display("FAIL rst_data got %h exp 0", {if_data, mem_rdata}); end
    checks++; if ({if_done, mem_done, ram_wr} !== 3'b000) begin errors++; $display("FAIL rst_ctl got %b exp 000", {if_done, mem_done, ram_wr}); end
    checks++; if ({ram_addr, ram_dout} !== 40'h0) begin errors++; $display("FAIL rst_ram got %h exp 0", {ram_addr, ram_dout}); end
    if_req = 1'b0; mem_req = 1'b1;
    @(negedge clk);
    checks++; if ({stallreq_from_if, stallreq_from_mem} !== 2'b01) begin errors++; $display("FAIL rst_stall_pair got %b exp 01", {stallreq_from_if, stallreq_from_mem}); end
    mem_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_word_fetch();
    logic [31:0] exp_addr [0:5];
    exp_addr[0] = 32'h0; exp_addr[1] = 32'h1000; exp_addr[2] = 32'h1001;
    exp_addr[3] = 32'h1002; exp_addr[4] = 32'h1003; exp_addr[5] = 32'h1003;
    if_req = 1'b1; if_addr = 32'h1000;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) begin
        checks++; if (stallreq_from_if !== 1'b1 || if_done !== 1'b0) begin errors++; $display("FAIL fetch_stall k=%0d got stall=%b done=%b exp 1 0", k, stallreq_from_if, if_done); end
        checks++; if (ram_addr !== exp_addr[k] || ram_wr !== 1'b0) begin errors++; $display("FAIL fetch_addr k=%0d got %h wr=%b exp %h wr=0", k, ram_addr, ram_wr, exp_addr[k]); end
      end else begin
        checks++; if (if_done !== 1'b1 || stallreq_from_if !== 1'b0) begin errors++; $display("FAIL fetch_done got done=%b stall=%b exp 1 0", if_done, stallreq_from_if); end
        checks++; if (if_data !== 32'h00A00093) begin errors++; $display("FAIL fetch_data got %h exp 00a00093", if_data); end
      end
      next_cycle();
    end
    if_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h1000;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h2000;
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (k == 6) begin
        checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_mem got done=%b data=%h exp 1 deadbeef", mem_done, mem_rdata); end
        checks++; if (if_done !== 1'b0 || stallreq_from_if !== 1'b1 || stallreq_from_mem !== 1'b0) begin errors++; $display("FAIL sim_if_wait got done=%b si=%b sm=%b exp 0 1 0", if_done, stallreq_from_if, stallreq_from_mem); end
        checks++; if (if_data !== 32'h00A00093) begin errors++; $display("FAIL sim_if_hold got %h exp 00a00093", if_data); end
      end
      if (k == 12) begin
        checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL sim_if_early got %b exp 0", if_done); end
      end
      if (k == 13) begin
        checks++; if (if_done !== 1'b1 || mem_done !== 1'b0) begin errors++; $display("FAIL sim_if_done got if=%b mem=%b exp 1 0", if_done, mem_done); end
        checks++; if (mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_mem_hold got %h exp deadbeef", mem_rdata); end
      end
      next_cycle();
      if (k == 6) mem_req = 1'b0;
    end
    if_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_byte_store();
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h3003; mem_wdata = 32'h12345678;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL st_idle_wr got %b exp 0", ram_wr); end
      end
      if (k == 1) begin
        checks++; if (ram_wr !== 1'b1 || ram_addr !== 32'h3003 || ram_dout !== 8'h78) begin errors++; $display("FAIL st_bus got wr=%b a=%h d=%h exp 1 3003 78", ram_wr, ram_addr, ram_dout); end
      end
      if (k == 2) begin
        checks++; if (mem_done !== 1'b1 || ram_wr !== 1'b0) begin errors++; $display("FAIL st_done got done=%b wr=%b exp 1 0", mem_done, ram_wr); end
        checks++; if (mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_rdata_hold got %h exp deadbeef", mem_rdata); end
      end
      next_cycle();
    end
    mem_req = 1'b0;
    next_cycle();
    checks++; if (ram[16'h3003] !== 8'h78 || ram[16'h3004] !== 8'h55) begin errors++; $display("FAIL st_ram got %h %h exp 78 55", ram[16'h3003], ram[16'h3004]); end
  endtask

  task automatic test_half_wrap();
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd1; mem_addr = 32'hFFFFFFFF;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (ram_addr !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_a0 got %h exp ffffffff", ram_addr); end
      end
      if (k == 2 || k == 3) begin
        checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL wrap_a1 k=%0d got %h exp 0", k, ram_addr); end
      end
      if (k == 3) begin
        checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL wrap_early got %b exp 0", mem_done); end
      end
      if (k == 4) begin
        checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'h0000ABCD) begin errors++; $display("FAIL wrap_data got done=%b %h exp 1 0000abcd", mem_done, mem_rdata); end
      end
      next_cycle();
    end
    mem_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_store();
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h4000; mem_wdata = 32'hA1B2C3D4;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (ram_wr !== 1'b1 || ram_addr !== 32'h4000 || ram_dout !== 8'hD4) begin errors++; $display("FAIL rm_b0 got wr=%b a=%h d=%h exp 1 4000 d4", ram_wr, ram_addr, ram_dout); end
      end
      if (k == 2) begin
        checks++; if (ram_wr !== 1'b1 || ram_addr !== 32'h4001 || ram_dout !== 8'hC3) begin errors++; $display("FAIL rm_b1 got wr=%b a=%h d=%h exp 1 4001 c3", ram_wr, ram_addr, ram_dout); end
      end
      if (k == 3) begin
        checks++; if (ram_wr !== 1'b0 || ram_addr !== 32'h0 || ram_dout !== 8'h0) begin errors++; $display("FAIL rm_bus got wr=%b a=%h d=%h exp 0 0 0", ram_wr, ram_addr, ram_dout); end
        checks++; if ({if_data, mem_rdata} !== 64'h0) begin errors++; $display("FAIL rm_data got %h exp 0", {if_data, mem_rdata}); end
      end
      if (k >= 3) begin
        checks++; if (mem_done !== 1'b0 || if_done !== 1'b0) begin errors++; $display("FAIL rm_nodone k=%0d got %b%b exp 00", k, mem_done, if_done); end
      end
      next_cycle();
      if (k == 1) rst = 1'b1;
      if (k == 2) begin rst = 1'b0; mem_req = 1'b0; end
    end
    // Fresh byte load of the byte that did reach the RAM.
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h4000;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) begin
        checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'h000000D4) begin errors++; $display("FAIL rm_fresh got done=%b %h exp 1 000000d4", mem_done, mem_rdata); end
      end
      next_cycle();
    end
    mem_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    if_req = 1'b1; if_addr = 32'h2000;
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (k == 6 || k == 13) begin
        checks++; if (if_done !== 1'b1 || if_data !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_done k=%0d got done=%b %h exp 1 deadbeef", k, if_done, if_data); end
      end else begin
        checks++; if (if_done !== 1'b0 || stallreq_from_if !== 1'b1) begin errors++; $display("FAIL b2b_wait k=%0d got done=%b stall=%b exp 0 1", k, if_done, stallreq_from_if); end
      end
      next_cycle();
    end
    if_req = 1'b0;
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
    next_cycle();
    preload(16'h1000, 8'h93); preload(16'h1001, 8'h00);
    preload(16'h1002, 8'hA0); preload(16'h1003, 8'h00);
    preload(16'h2000, 8'hEF); preload(16'h2001, 8'hBE);
    preload(16'h2002, 8'hAD); preload(16'h2003, 8'hDE);
    preload(16'h3003, 8'h00); preload(16'h3004, 8'h55);
    preload(16'hFFFF, 8'hCD); preload(16'h0000, 8'hAB);
    test_reset();
    test_word_fetch();
    test_simultaneous();
    test_byte_store();
    test_half_wrap();
    test_reset_mid_store();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
